// File: rtl/div_radix2_pkg.sv
// Shared definitions for the execute-stage radix-2 divider: FSM state
// encodings and the ALU control codes that select DIV/DIVU (shared with aludec).
package div_radix2_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } divState_t;

   // alucontrol encodings decoded by aludec for the divide instructions
   localparam logic [3:0] ALU_DIV  = 4'b1010;
   localparam logic [3:0] ALU_DIVU = 4'b1011;

endpackage

// File: rtl/div_radix2_cond_neg.sv
// Conditional two's-complement negation: result = neg ? -value : value.
// Used for operand magnitudes on the way in and the sign fix on the way out.
module cond_neg #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] value,
   input  logic             neg,
   output logic [WIDTH-1:0] result
);

   // negation wraps modulo 2^WIDTH, so the most negative value maps to itself
   always_comb begin
      result = neg ? -value : value;
   end

endmodule

// File: rtl/div_radix2.sv
// Restoring radix-2 integer divider for the E stage of the MIPS pipeline.
// Produces one quotient bit per cycle and returns {HI,LO} = {remainder, quotient}
// after a fixed WIDTH+1 cycle latency, stalling F/D/E while it iterates.
module div_radix2
   import div_radix2_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               startE,
   input  logic               signedE,
   input  logic               annulE,
   input  logic [WIDTH-1:0]   aE,
   input  logic [WIDTH-1:0]   bE,
   output logic [2*WIDTH-1:0] resultE,
   output logic               readyE,
   output logic               stallE
);

   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

   divState_t        state;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] aHold;
   logic             signQ;
   logic             signR;
   logic             div0;

   logic [WIDTH-1:0] absA;
   logic [WIDTH-1:0] absB;
   logic [WIDTH:0]   remShift;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] nextRem;
   logic [WIDTH-1:0] nextQuo;
   logic [WIDTH-1:0] fixedQuo;
   logic [WIDTH-1:0] fixedRem;

   cond_neg #(.WIDTH(WIDTH)) negA (
      .value  (aE),
      .neg    (signedE & aE[WIDTH-1]),
      .result (absA)
   );

   cond_neg #(.WIDTH(WIDTH)) negB (
      .value  (bE),
      .neg    (signedE & bE[WIDTH-1]),
      .result (absB)
   );

   // The final iteration's quotient/remainder feed the sign fix directly so
   // the result can be registered on the same edge that enters DONE.
   cond_neg #(.WIDTH(WIDTH)) negQuo (
      .value  (nextQuo),
      .neg    (signQ),
      .result (fixedQuo)
   );

   cond_neg #(.WIDTH(WIDTH)) negRem (
      .value  (nextRem),
      .neg    (signR),
      .result (fixedRem)
   );

   // One restoring step: shift in the next dividend bit and keep the trial
   // subtraction only when it does not go negative.
   always_comb begin
      remShift = {rem, quo[WIDTH-1]};
      trial    = remShift - {1'b0, divisor};
      nextRem  = remShift[WIDTH-1:0];
      nextQuo  = {quo[WIDTH-2:0], 1'b0};
      if (!trial[WIDTH]) begin
         nextRem = trial[WIDTH-1:0];
         nextQuo = {quo[WIDTH-2:0], 1'b1};
      end
   end

   // Hold the pipeline from the accepting cycle through the last iteration;
   // dropping it in DONE lets the instruction advance alongside readyE.
   always_comb begin
      stallE = ((state == DIV_IDLE) && startE && !annulE) || (state == DIV_BUSY);
   end

   // Divider FSM: latch operands, iterate WIDTH times, then publish the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= DIV_IDLE;
         count   <= '0;
         rem     <= '0;
         quo     <= '0;
         divisor <= '0;
         aHold   <= '0;
         signQ   <= 1'b0;
         signR   <= 1'b0;
         div0    <= 1'b0;
         resultE <= '0;
         readyE  <= 1'b0;
      end else begin
         readyE <= 1'b0;
         case (state)
            DIV_IDLE: begin
               if (startE && !annulE) begin
                  quo     <= absA;
                  divisor <= absB;
                  rem     <= '0;
                  count   <= '0;
                  signQ   <= signedE & (aE[WIDTH-1] ^ bE[WIDTH-1]);
                  signR   <= signedE & aE[WIDTH-1];
                  div0    <= (bE == '0);
                  aHold   <= aE;
                  state   <= DIV_BUSY;
               end
            end
            DIV_BUSY: begin
               if (annulE) begin
                  state <= DIV_IDLE;
               end else begin
                  rem   <= nextRem;
                  quo   <= nextQuo;
                  count <= count + 1'b1;
                  if (count == LAST_COUNT) begin
                     state  <= DIV_DONE;
                     readyE <= 1'b1;
                     if (div0) begin
                        resultE <= {aHold, {WIDTH{1'b1}}};
                     end else begin
                        resultE <= {fixedRem, fixedQuo};
                     end
                  end
               end
            end
            DIV_DONE: begin
               state <= DIV_IDLE;
            end
            default: begin
               state <= DIV_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_radix2.sv
// Self-checking bench for div_radix2: table of directed divides with full
// latency/stall checks, plus annul and reset sequences.
module tb_div_radix2;

   logic        clk = 1'b0;
   logic        rst;
   logic        startE;
   logic        signedE;
   logic        annulE;
   logic [31:0] aE;
   logic [31:0] bE;
   logic [63:0] resultE;
   logic        readyE;
   logic        stallE;

   int testsRun = 0;
   int testsFailed = 0;

   typedef struct {
      string       name;
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } divVec_t;

   divVec_t vecs[9];

   div_radix2 #(.WIDTH(32), .CNT_W(6)) dut (
      .clk     (clk),
      .rst     (rst),
      .startE  (startE),
      .signedE (signedE),
      .annulE  (annulE),
      .aE      (aE),
      .bE      (bE),
      .resultE (resultE),
      .readyE  (readyE),
      .stallE  (stallE)
   );

   always #5 clk = ~clk;

   // hard time limit so the bench can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, actual, expected);
      end
   endtask

   // Issue one divide at the current cycle T and check stall, ready and result
   // timing through T+34. Called just after a falling edge; returns likewise.
   task automatic applyStimulus(input string name, input logic sgn, input logic [31:0] a,
                                input logic [31:0] b, input logic [63:0] exp);
      int stallBad;
      int readyBad;
      startE  = 1'b1;
      signedE = sgn;
      annulE  = 1'b0;
      aE      = a;
      bE      = b;
      #1;
      checkOutput({name, ".stallT"}, {63'd0, stallE}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      startE = 1'b0;
      aE     = '0;
      bE     = '0;
      stallBad = 0;
      readyBad = 0;
      for (int k = 1; k <= 32; k++) begin
         #1;
         if (stallE !== 1'b1) stallBad++;
         if (readyE !== 1'b0) readyBad++;
         @(negedge clk);
      end
      #1;
      checkOutput({name, ".stallWindowBad"}, 64'(stallBad), 64'd0);
      checkOutput({name, ".earlyReady"}, 64'(readyBad), 64'd0);
      checkOutput({name, ".ready"}, {63'd0, readyE}, 64'd1);
      checkOutput({name, ".stallDone"}, {63'd0, stallE}, 64'd0);
      checkOutput({name, ".result"}, resultE, exp);
      @(negedge clk);
      #1;
      checkOutput({name, ".readyPulse"}, {63'd0, readyE}, 64'd0);
      checkOutput({name, ".resultHold"}, resultE, exp);
   endtask

   initial begin
      logic [63:0] lastResult;
      int          readyCount;
      int          stallCount;

      vecs[0] = '{"divu100_7",   1'b0, 32'd100,        32'd7,          64'h00000002_0000000E};
      vecs[1] = '{"divNeg7_2",   1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD};
      vecs[2] = '{"div7_neg2",   1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD};
      vecs[3] = '{"divOverflow", 1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000};
      vecs[4] = '{"divuByZero",  1'b0, 32'h12345678,   32'd0,          64'h12345678_FFFFFFFF};
      vecs[5] = '{"divByZero",   1'b1, 32'hFFFFFFF0,   32'd0,          64'hFFFFFFF0_FFFFFFFF};
      vecs[6] = '{"divuMax_1",   1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF};
      vecs[7] = '{"divuNeg7_2",  1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC};
      vecs[8] = '{"divNeg100_7", 1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E};

      rst     = 1'b1;
      startE  = 1'b0;
      signedE = 1'b0;
      annulE  = 1'b0;
      aE      = '0;
      bE      = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("reset.result", resultE, 64'd0);
      checkOutput("reset.ready", {63'd0, readyE}, 64'd0);
      checkOutput("reset.stall", {63'd0, stallE}, 64'd0);
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp);
      end
      lastResult = vecs[8].exp;

      // annul in BUSY at T+10, then a fresh DIVU 9/3 at T+12
      @(negedge clk);
      startE = 1'b1; signedE = 1'b0; aE = 32'd100; bE = 32'd7;
      @(negedge clk);
      startE = 1'b0;
      repeat (9) @(negedge clk);
      annulE = 1'b1;
      #1;
      checkOutput("annul.stallBusy", {63'd0, stallE}, 64'd1);
      @(negedge clk);
      annulE = 1'b0;
      #1;
      checkOutput("annul.stallDropped", {63'd0, stallE}, 64'd0);
      checkOutput("annul.noReady", {63'd0, readyE}, 64'd0);
      checkOutput("annul.resultKept", resultE, lastResult);
      @(negedge clk);
      applyStimulus("afterAnnul9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

      // reset mid-divide at T+5
      @(negedge clk);
      startE = 1'b1; signedE = 1'b1; aE = 32'd50; bE = 32'd5;
      @(negedge clk);
      startE = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("midReset.stall", {63'd0, stallE}, 64'd0);
      checkOutput("midReset.ready", {63'd0, readyE}, 64'd0);
      checkOutput("midReset.result", resultE, 64'd0);

      // start together with annul in IDLE must not launch a divide
      @(negedge clk);
      startE = 1'b1; annulE = 1'b1; aE = 32'd9; bE = 32'd3;
      #1;
      checkOutput("startAnnul.stall", {63'd0, stallE}, 64'd0);
      @(negedge clk);
      startE = 1'b0; annulE = 1'b0;
      readyCount = 0;
      stallCount = 0;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (readyE) readyCount++;
         if (stallE) stallCount++;
         @(negedge clk);
      end
      checkOutput("startAnnul.noReady", 64'(readyCount), 64'd0);
      checkOutput("startAnnul.noStall", 64'(stallCount), 64'd0);
      checkOutput("startAnnul.result", resultE, 64'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
